// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with byte/half/word access, load extension and a
// request/done handshake with WAIT_CYCLES wait states. Optional: DMEM_MISALIGN_TRAP_EN.
//
// state  | meaning
// IDLE   | no access in flight; accepts req_i
// WAIT   | access latched; down-counter runs WAIT_CYCLES..0, access performed at 0
// RESP   | done_o pulse; accepts req_i again
module data_memory_sized #(
    parameter int DEPTH_BYTES = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int DATA_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("data_memory_sized: DATA_W must be 32");
    end
    if ((DEPTH_BYTES < 4) || ((DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0)) begin : g_bad_depth
        $error("data_memory_sized: DEPTH_BYTES must be a power of two >= 4");
    end
    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_wait
        $error("data_memory_sized: WAIT_CYCLES must be 0..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic            r_uns;
    logic [1:0]      r_size;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic [7:0]      r_mem [DEPTH_BYTES];

    logic            w_accept;
    logic            w_commit;
    logic            w_trap;
    logic [AW-1:0]   w_a0, w_a1, w_a2, w_a3;
    logic [7:0]      w_b0, w_b1, w_b2, w_b3;
    logic [31:0]     w_load;
    logic            w_addr_unused;

    assign w_addr_unused = ^addr_i[31:AW];

    assign busy_o   = (r_state == S_WAIT);
    assign done_o   = (r_state == S_RESP);
    assign rdata_o  = r_rdata;
    assign w_accept = req_i && !busy_o;
    assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef DMEM_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_err;

    assign w_misalign = ((r_size == 2'b01) && r_addr[0]) ||
                        (r_size[1] && (r_addr[1:0] != 2'b00));
    assign w_trap     = w_misalign;
    assign err_o      = r_err && done_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_commit) begin
            r_err <= w_misalign;
        end
    end
`else
    assign w_trap = 1'b0;
    assign err_o  = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = w_accept ? S_WAIT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte lanes wrap within the array, so top-of-memory accesses continue at 0.
    assign w_a0 = r_addr;
    assign w_a1 = r_addr + AW'(1);
    assign w_a2 = r_addr + AW'(2);
    assign w_a3 = r_addr + AW'(3);
    assign w_b0 = r_mem[w_a0];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    always_comb begin
        w_load = {w_b3, w_b2, w_b1, w_b0};
        case (r_size)
            2'b00:   w_load = r_uns ? {24'h0, w_b0} : {{24{w_b0[7]}}, w_b0};
            2'b01:   w_load = r_uns ? {16'h0, w_b1, w_b0} : {{16{w_b1[7]}}, w_b1, w_b0};
            default: w_load = {w_b3, w_b2, w_b1, w_b0};
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            if (w_accept) begin
                r_cnt   <= WAIT_INIT;
                r_we    <= we_i;
                r_uns   <= unsigned_i;
                r_size  <= size_i;
                r_addr  <= addr_i[AW-1:0];
                r_wdata <= wdata_i;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit && !r_we && !w_trap) begin
                r_rdata <= w_load;
            end
        end
    end

    // A reset on the commit edge aborts the store.
    always_ff @(posedge clk_i) begin
        if (w_commit && r_we && !w_trap && !rst_i) begin
            r_mem[w_a0] <= r_wdata[7:0];
            if (r_size != 2'b00) begin
                r_mem[w_a1] <= r_wdata[15:8];
            end
            if (r_size[1]) begin
                r_mem[w_a2] <= r_wdata[23:16];
                r_mem[w_a3] <= r_wdata[31:24];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed self-checking bench: one instance with WAIT_CYCLES=0 for function,
// one with WAIT_CYCLES=3 for handshake timing.
module tb_data_memory_sized;

    logic        clk;
    logic        rst;
    logic        req0, req3;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy0, done0, err0;
    logic [31:0] rdata0;
    logic        busy3, done3, err3;
    logic [31:0] rdata3;

    int checks   = 0;
    int failures = 0;

    data_memory_sized #(.DEPTH_BYTES(32), .WAIT_CYCLES(0), .DATA_W(32)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we), .size_i(size),
        .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy0), .done_o(done0), .rdata_o(rdata0), .err_o(err0)
    );

    data_memory_sized #(.DEPTH_BYTES(32), .WAIT_CYCLES(3), .DATA_W(32)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .we_i(we), .size_i(size),
        .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy3), .done_o(done3), .rdata_o(rdata3), .err_o(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One access on the WAIT_CYCLES=0 instance; returns what was seen during done_o.
    task automatic acc0(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        we = w; size = sz; uns = u; addr = a; wdata = wd; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        chk("busy_after_accept", {31'h0, busy0}, 32'h1);
        n = 0;
        while (!done0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_latency", 32'(n), 32'd1);
        chk("busy_in_resp", {31'h0, busy0}, 32'h0);
        rd = rdata0;
        er = err0;
    endtask

    task automatic load0(input string tag, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        acc0(1'b0, sz, u, a, 32'h0, rd, er);
        chk(tag, rd, exp_rd);
        chk({tag, "_err"}, {31'h0, er}, {31'h0, exp_er});
    endtask

    task automatic store0(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        acc0(1'b1, sz, 1'b0, a, wd, rd, er);
        chk({tag, "_err"}, {31'h0, er}, {31'h0, exp_er});
    endtask

    initial begin
        int n;
        rst = 1'b1; req0 = 1'b0; req3 = 1'b0;
        we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, busy0}, 32'h0);
        chk("rst_done", {31'h0, done0}, 32'h0);
        chk("rst_rdata", rdata0, 32'h0);
        chk("rst_err", {31'h0, err0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", {31'h0, busy0}, 32'h0);
        chk("idle_done", {31'h0, done0}, 32'h0);

        // Reset during WAIT must abort the store and suppress done_o.
        store0("st_w4", 2'b10, 32'd4, 32'hA5A5A5A5, 1'b0);
        chk("store_keeps_rdata", rdata0, 32'h0);
        @(negedge clk);
        we = 1'b1; size = 2'b10; addr = 32'd4; wdata = 32'h12345678; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        rst  = 1'b1;
        chk("abort_in_wait", {31'h0, busy0}, 32'h1);
        @(posedge clk); #1;
        chk("abort_no_done", {31'h0, done0}, 32'h0);
        chk("abort_busy", {31'h0, busy0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_no_done_late", {31'h0, done0}, 32'h0);
        end
        load0("ld_w4_after_abort", 2'b10, 1'b0, 32'd4, 32'hA5A5A5A5, 1'b0);

        store0("st_deadbeef", 2'b10, 32'd8, 32'hDEADBEEF, 1'b0);
        load0("ld_w8", 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, 1'b0);
        load0("ld_b8_s", 2'b00, 1'b0, 32'd8, 32'hFFFFFFEF, 1'b0);
        load0("ld_b9_s", 2'b00, 1'b0, 32'd9, 32'hFFFFFFBE, 1'b0);
        load0("ld_b10_s", 2'b00, 1'b0, 32'd10, 32'hFFFFFFAD, 1'b0);
        load0("ld_b11_s", 2'b00, 1'b0, 32'd11, 32'hFFFFFFDE, 1'b0);
        load0("ld_b8_u", 2'b00, 1'b1, 32'd8, 32'h000000EF, 1'b0);
        load0("ld_h8_s", 2'b01, 1'b0, 32'd8, 32'hFFFFBEEF, 1'b0);
        load0("ld_h10_u", 2'b01, 1'b1, 32'd10, 32'h0000DEAD, 1'b0);
        load0("ld_size11_w8", 2'b11, 1'b1, 32'd8, 32'hDEADBEEF, 1'b0);

        store0("st_b3", 2'b00, 32'd3, 32'h12345680, 1'b0);
        chk("store_keeps_rdata2", rdata0, 32'hDEADBEEF);
        load0("ld_b3_s", 2'b00, 1'b0, 32'd3, 32'hFFFFFF80, 1'b0);
        load0("ld_b3_u", 2'b00, 1'b1, 32'd3, 32'h00000080, 1'b0);
        load0("ld_w4_byte_isolated", 2'b10, 1'b0, 32'd4, 32'hA5A5A5A5, 1'b0);
        store0("st_h6", 2'b01, 32'd6, 32'hAAAA7FFF, 1'b0);
        load0("ld_h6_s", 2'b01, 1'b0, 32'd6, 32'h00007FFF, 1'b0);
        load0("ld_w4_after_half", 2'b10, 1'b0, 32'd4, 32'h7FFFA5A5, 1'b0);

        // Upper address bits are ignored: 0x22 aliases 2.
        store0("st_h22", 2'b01, 32'h22, 32'h0000BEEF, 1'b0);
        load0("ld_h2_u", 2'b01, 1'b1, 32'd2, 32'h0000BEEF, 1'b0);
        load0("ld_hffffffe2_s", 2'b01, 1'b0, 32'hFFFFFFE2, 32'hFFFFBEEF, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
        store0("trap_st_w2", 2'b10, 32'd2, 32'hCAFEF00D, 1'b1);
        load0("trap_w4_unchanged", 2'b10, 1'b0, 32'd4, 32'h7FFFA5A5, 1'b0);
        load0("trap_h2_unchanged", 2'b01, 1'b1, 32'd2, 32'h0000BEEF, 1'b0);
        load0("trap_ld_h1", 2'b01, 1'b0, 32'd1, 32'h0000BEEF, 1'b1);
`else
        store0("wrap_st_w30", 2'b10, 32'd30, 32'h11223344, 1'b0);
        load0("wrap_b30", 2'b00, 1'b1, 32'd30, 32'h00000044, 1'b0);
        load0("wrap_b31", 2'b00, 1'b1, 32'd31, 32'h00000033, 1'b0);
        load0("wrap_b20", 2'b00, 1'b1, 32'h20, 32'h00000022, 1'b0);
        load0("wrap_b21", 2'b00, 1'b1, 32'h21, 32'h00000011, 1'b0);
        load0("wrap_w30", 2'b10, 1'b0, 32'd30, 32'h11223344, 1'b0);
        load0("alias_h20_u", 2'b01, 1'b1, 32'h20, 32'h00001122, 1'b0);
        load0("misalign_h31_s", 2'b01, 1'b0, 32'd31, 32'h00002233, 1'b0);
`endif

        // WAIT_CYCLES=3: four busy cycles, done in the fifth, held req accepted from RESP.
        @(negedge clk);
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'd0; wdata = 32'h01020304; req3 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk("w3_busy", {31'h0, busy3}, 32'h1);
            chk("w3_done_low", {31'h0, done3}, 32'h0);
            @(posedge clk); #1;
        end
        chk("w3_done", {31'h0, done3}, 32'h1);
        chk("w3_busy_resp", {31'h0, busy3}, 32'h0);
        chk("w3_err", {31'h0, err3}, 32'h0);
        we = 1'b0;
        @(posedge clk); #1;
        chk("w3_reaccept_busy", {31'h0, busy3}, 32'h1);
        chk("w3_reaccept_done", {31'h0, done3}, 32'h0);
        req3 = 1'b0;
        n = 0;
        while (!done3 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w3_load_latency", 32'(n), 32'd4);
        chk("w3_load_data", rdata3, 32'h01020304);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
